seg7_to_bin: RTL and testbench

- Receive-side counterpart to the team's binary-to-7-segment display driver.
- Samples an external 7-segment bus {A..G, active-high} plus the "tens" LED and synchronizes them.
- Rejects glitches and transitions with a stability filter, then decodes the pattern back to a 4-bit binary value 0..15.
- Presents the result on a valid/ready output port, with an error flag for illegal patterns and a sticky overrun flag.

---
 rtl/seg7_pkg.sv | 67 ++++++
 rtl/seg7_stab_filter.sv | 79 +++++++
 rtl/seg7_to_bin.sv | 96 +++++++++
 tb/tb_seg7_to_bin.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment receive path and the display driver:
// segment patterns {A..G} (active-high), filter state encoding and the
// pattern-to-binary decode.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Full synchronized word {led, seg}; a dark display is all zeros.
  localparam logic [7:0] WORD_BLANK = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,  // candidate is the blank word
    S_SETTLE = 2'd1,  // counting identical samples
    S_LOCKED = 2'd2   // candidate accepted, waiting for a change
  } state_t;

  typedef struct packed {
    logic [3:0] value;
    logic       err;
  } dec_t;

  // Pattern plus tens LED back to 0..15. Anything not displayable by the
  // driver (unknown pattern, or tens LED with a digit above 5) is an error
  // and reports value 0.
  function automatic dec_t seg7_decode(input logic [6:0] pat, input logic led);
    dec_t       r;
    logic [3:0] d;
    logic       ok;
    ok = 1'b1;
    d  = 4'd0;
    case (pat)
      SEG_0:   d = 4'd0;
      SEG_1:   d = 4'd1;
      SEG_2:   d = 4'd2;
      SEG_3:   d = 4'd3;
      SEG_4:   d = 4'd4;
      SEG_5:   d = 4'd5;
      SEG_6:   d = 4'd6;
      SEG_7:   d = 4'd7;
      SEG_8:   d = 4'd8;
      SEG_9:   d = 4'd9;
      default: ok = 1'b0;
    endcase
    r.value = 4'd0;
    r.err   = 1'b0;
    if (!ok || (led && (d > 4'd5))) begin
      r.err = 1'b1;
    end else if (led) begin
      // d <= 5 here, so d + 10 <= 15 always fits in 4 bits.
      r.value = d + 4'd10;
    end else begin
      r.value = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_stab_filter.sv
// Synchronizes the asynchronous segment bus and tens LED, waits for the word
// to hold still for STABLE_CYCLES samples, and strobes acc_o once per new
// accepted word. Repeats of the last accepted word are suppressed until the
// display goes blank.
module seg7_stab_filter
  import seg7_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_i,
  input  logic       led_i,
  output logic       acc_o,
  output logic [7:0] word_o
);

  localparam int             CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]                  w;
  logic [7:0]                  cand_q;
  logic [7:0]                  last_q;
  logic [CW-1:0]               cnt_q;
  state_t                      state_q;

  // Synchronizer chain: all 8 bits move together, stage 0 samples the pins.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= {led_i, seg_i};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign w = sync_q[SYNC_STAGES-1];

  // Strobe is decoded from registered state so the top can capture the
  // word on the very edge the candidate completes its stable run.
  assign acc_o  = (state_q == S_SETTLE) && (w == cand_q) &&
                  (cnt_q == CNT_LAST) && (cand_q != last_q);
  assign word_o = cand_q;

  // Stability FSM: restart on any change, accept after a full stable run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
    end else if (w != cand_q) begin
      cand_q <= w;
      cnt_q  <= CNT_ONE;
      if (w == WORD_BLANK) begin
        state_q <= S_IDLE;
        // Forget the last word so the same digit after a blank shows again.
        last_q  <= '0;
      end else begin
        state_q <= S_SETTLE;
      end
    end else if (state_q == S_SETTLE) begin
      if (cnt_q == CNT_LAST) begin
        state_q <= S_LOCKED;
        last_q  <= cand_q;
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/seg7_to_bin.sv
// Receive side of the 7-segment link: filters the bus, decodes accepted
// words to 0..15 and holds them in a valid/ready output register with an
// error flag and a sticky overrun flag for words dropped under backpressure.
module seg7_to_bin
  import seg7_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       led_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_bin,
  output logic       out_err,
  output logic       overrun,
  input  logic       clr_ovr
);

  logic       acc;
  logic [7:0] word;
  dec_t       dec;

  logic       valid_d, valid_q;
  logic [3:0] bin_d,   bin_q;
  logic       err_d,   err_q;
  logic       ovr_d,   ovr_q;

  seg7_stab_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .seg_i (word_in_seg()),
    .led_i (led_in),
    .acc_o (acc),
    .word_o(word)
  );

  function automatic logic [6:0] word_in_seg();
    return seg_in;
  endfunction

  // Next state of the output register and the overrun flag.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    valid_d = valid_q;
    bin_d   = bin_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    dec     = seg7_decode(word[6:0], word[7]);

    if (clr_ovr) begin
      ovr_d = 1'b0;
    end

    if (acc) begin
      if (!valid_q || out_ready) begin
        // Slot is free, or is being emptied on this same edge.
        valid_d = 1'b1;
        bin_d   = dec.value;
        err_d   = dec.err;
      end else begin
        // Held word wins; a set beats a simultaneous clear.
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output register and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      bin_q   <= 4'd0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_bin   = bin_q;
  assign out_err   = err_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_seg7_to_bin.sv
// Directed bench for seg7_to_bin with hand-computed expectations.
module tb_seg7_to_bin;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       led_in;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_bin;
  logic       out_err;
  logic       overrun;
  logic       clr_ovr;

  int n_cmp = 0;
  int n_bad = 0;

  seg7_to_bin #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .seg_in   (seg_in),
    .led_in   (led_in),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_bin  (out_bin),
    .out_err  (out_err),
    .overrun  (overrun),
    .clr_ovr  (clr_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a word for n edges; count cycles with out_valid high, note the
  // edge of the first one and the last observed bin/err.
  task automatic hold(input logic [6:0] seg, input logic led, input int n,
                      output int pulses, output int first,
                      output logic [3:0] bin, output logic err);
    seg_in = seg;
    led_in = led;
    pulses = 0;
    first  = 0;
    bin    = 4'd0;
    err    = 1'b0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (out_valid) begin
        pulses++;
        if (first == 0) first = i;
        bin = out_bin;
        err = out_err;
      end
    end
  endtask

  int         p, f, tot;
  logic [3:0] b;
  logic       e;

  initial begin
    rst_n     = 1'b0;
    seg_in    = 7'h00;
    led_in    = 1'b0;
    out_ready = 1'b1;
    clr_ovr   = 1'b0;
    repeat (2) step();
    check("rst_valid",   32'(out_valid), 32'd0);
    check("rst_bin",     32'(out_bin),   32'd0);
    check("rst_err",     32'(out_err),   32'd0);
    check("rst_overrun", 32'(overrun),   32'd0);
    rst_n = 1'b1;
    hold(7'h00, 1'b0, 4, p, f, b, e);

    // Digit 3: one pulse rising on edge 6.
    hold(7'h79, 1'b0, 10, p, f, b, e);
    check("d3_pulses", 32'(p), 32'd1);
    check("d3_edge",   32'(f), 32'd6);
    check("d3_bin",    32'(b), 32'd3);
    check("d3_err",    32'(e), 32'd0);

    // Tens LED with 2 -> 12; tens LED with 7 -> error.
    hold(7'h6D, 1'b1, 10, p, f, b, e);
    check("d12_pulses", 32'(p), 32'd1);
    check("d12_bin",    32'(b), 32'hC);
    check("d12_err",    32'(e), 32'd0);
    hold(7'h70, 1'b1, 10, p, f, b, e);
    check("t7_pulses", 32'(p), 32'd1);
    check("t7_bin",    32'(b), 32'd0);
    check("t7_err",    32'(e), 32'd1);

    // Short digit between blanks is rejected.
    hold(7'h00, 1'b0, 6, p, f, b, e); tot = p;
    hold(7'h30, 1'b0, 2, p, f, b, e); tot += p;
    hold(7'h00, 1'b0, 8, p, f, b, e); tot += p;
    check("glitch_short", 32'(tot), 32'd0);

    // Same digit re-emitted after a blank.
    hold(7'h5B, 1'b0, 8, p, f, b, e);
    check("d5a_pulses", 32'(p), 32'd1);
    check("d5a_bin",    32'(b), 32'd5);
    hold(7'h00, 1'b0, 8, p, f, b, e);
    check("blank_pulses", 32'(p), 32'd0);
    hold(7'h5B, 1'b0, 8, p, f, b, e);
    check("d5b_pulses", 32'(p), 32'd1);
    check("d5b_bin",    32'(b), 32'd5);

    // One-cycle non-blank glitch inside a held 5 does not duplicate it.
    hold(7'h5B, 1'b0, 4, p, f, b, e);  tot = p;
    hold(7'h5A, 1'b0, 1, p, f, b, e);  tot += p;
    hold(7'h5B, 1'b0, 10, p, f, b, e); tot += p;
    check("glitch_dup", 32'(tot), 32'd0);

    // Illegal pattern.
    hold(7'h00, 1'b0, 8, p, f, b, e);
    hold(7'h77, 1'b0, 8, p, f, b, e);
    check("ill_pulses", 32'(p), 32'd1);
    check("ill_bin",    32'(b), 32'd0);
    check("ill_err",    32'(e), 32'd1);

    // Backpressure: 5 is held, 6 is dropped and flags overrun.
    hold(7'h00, 1'b0, 8, p, f, b, e);
    out_ready = 1'b0;
    hold(7'h5B, 1'b0, 8, p, f, b, e);
    check("bp_valid",   32'(out_valid), 32'd1);
    check("bp_bin",     32'(out_bin),   32'd5);
    check("bp_ovr_pre", 32'(overrun),   32'd0);
    hold(7'h00, 1'b0, 8, p, f, b, e);
    hold(7'h5F, 1'b0, 8, p, f, b, e);
    check("ovr_set",   32'(overrun),   32'd1);
    check("ovr_bin",   32'(out_bin),   32'd5);
    check("ovr_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    check("hs_valid",  32'(out_valid), 32'd0);
    check("ovr_stick", 32'(overrun),   32'd1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check("ovr_clr", 32'(overrun), 32'd0);

    // Reset mid-settle: nothing until a fresh full settle.
    hold(7'h00, 1'b0, 8, p, f, b, e);
    hold(7'h7F, 1'b0, 5, p, f, b, e);
    check("pre_rst_pulses", 32'(p), 32'd0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    step();
    rst_n = 1'b1;
    hold(7'h7F, 1'b0, 10, p, f, b, e);
    check("post_rst_pulses", 32'(p), 32'd1);
    check("post_rst_edge",   32'(f), 32'd6);
    check("post_rst_bin",    32'(b), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
